// File: rtl/ser_bit_feeder.sv
// Parallel-to-serial feeder, MSB first, optional post-word gap.
// Define SER_FEED_PARITY_EN to append an even-parity bit per word.
module ser_bit_feeder #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BC_LD = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

`ifdef SER_FEED_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    bcnt, bcnt_n;
    logic [3:0]       gcnt, gcnt_n;
    logic             last, accept;
    logic             so_n, sv_n, wd_n;
`ifdef SER_FEED_PARITY_EN
    logic             par, par_n;
`endif

    assign last   = (bcnt == '0);
    assign accept = data_valid & data_ready;

    // Ready is a pure decode of state; reset holds it low.
    always_comb begin
        data_ready = 1'b0;
        unique case (state)
            S_IDLE:  data_ready = 1'b1;
`ifdef SER_FEED_PARITY_EN
            S_SHIFT: data_ready = 1'b0;
            S_PAR:   data_ready = (GAP == 0);
`else
            S_SHIFT: data_ready = last && (GAP == 0);
`endif
            S_GAP:   data_ready = 1'b0;
            default: data_ready = 1'b0;
        endcase
        if (!rst) data_ready = 1'b0;
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        bcnt_n  = bcnt;
        gcnt_n  = gcnt;
`ifdef SER_FEED_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            S_IDLE: ;
            S_SHIFT: begin
                sreg_n = {sreg[WIDTH-2:0], 1'b0};
                bcnt_n = bcnt - 1'b1;
                if (last) begin
`ifdef SER_FEED_PARITY_EN
                    state_n = S_PAR;
`else
                    if (GAP > 0) begin
                        state_n = S_GAP;
                        gcnt_n  = GAP_LD;
                    end else begin
                        state_n = S_IDLE;
                    end
`endif
                end
            end
`ifdef SER_FEED_PARITY_EN
            S_PAR: begin
                if (GAP > 0) begin
                    state_n = S_GAP;
                    gcnt_n  = GAP_LD;
                end else begin
                    state_n = S_IDLE;
                end
            end
`endif
            S_GAP: begin
                if (gcnt == 4'd0) state_n = S_IDLE;
                else gcnt_n = gcnt - 4'd1;
            end
            default: state_n = S_IDLE;
        endcase
        // Ready is only high where a load is the right next step.
        if (accept) begin
            state_n = S_SHIFT;
            sreg_n  = data_in;
            bcnt_n  = BC_LD;
`ifdef SER_FEED_PARITY_EN
            par_n   = ^data_in;
`endif
        end
    end

    always_comb begin
        sv_n = (state_n == S_SHIFT);
        so_n = (state_n == S_SHIFT) & sreg_n[WIDTH-1];
`ifdef SER_FEED_PARITY_EN
        sv_n = sv_n | (state_n == S_PAR);
        so_n = so_n | ((state_n == S_PAR) & par_n);
        wd_n = (state_n == S_PAR);
`else
        wd_n = (state_n == S_SHIFT) && (bcnt_n == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sreg      <= '0;
            bcnt      <= '0;
            gcnt      <= 4'd0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            bcnt      <= bcnt_n;
            gcnt      <= gcnt_n;
            ser_out   <= so_n;
            ser_valid <= sv_n;
            word_done <= wd_n;
        end
    end

`ifdef SER_FEED_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par <= 1'b0;
        else par <= par_n;
    end
`endif

endmodule

// File: tb/tb_ser_bit_feeder.sv
// Scoreboard bench for ser_bit_feeder: GAP=0 and GAP=3 instances.
module tb_ser_bit_feeder;

`ifdef SER_FEED_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic b;
        logic d;
        int   c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din3;
    logic       dv0, dv3;
    logic       dr0, dr3, so0, so3, sv0, sv3, wd0, wd3;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   glo = 1;
    int   ghi = 0;
    exp_t q0[$];
    exp_t q3[$];
    exp_t x0, x3;

    always #5 clk = ~clk;

    ser_bit_feeder #(.WIDTH(8), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0),
        .data_ready(dr0), .ser_out(so0), .ser_valid(sv0),
        .word_done(wd0)
    );

    ser_bit_feeder #(.WIDTH(8), .GAP(3)) u3 (
        .clk(clk), .rst(rst), .data_in(din3), .data_valid(dv3),
        .data_ready(dr3), .ser_out(so3), .ser_valid(sv3),
        .word_done(wd3)
    );

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    function automatic void push(input int sel, input logic [7:0] w,
                                 input int e);
        exp_t t;
        for (int k = 0; k < 8; k++) begin
            t.b = w[7-k];
            t.d = (k == 7) && (PB == 0);
            t.c = e + 1 + k;
            if (sel == 0) q0.push_back(t);
            else q3.push_back(t);
        end
        if (PB == 1) begin
            t.b = ^w;
            t.d = 1'b1;
            t.c = e + 9;
            if (sel == 0) q0.push_back(t);
            else q3.push_back(t);
        end
    endfunction

    // Accept recorder: stimulus side of the scoreboard.
    always @(posedge clk) begin
        if (rst && dv0 && dr0) push(0, din0, cyc);
        if (rst && dv3 && dr3) push(3, din3, cyc);
        cyc <= cyc + 1;
    end

    // Monitor: pops whenever a DUT presents a serial bit.
    always @(negedge clk) begin
        if (rst) begin
            if (sv0) begin
                if (q0.size() == 0) chk("u0 unexpected valid", 32'(sv0), 0);
                else begin
                    x0 = q0.pop_front();
                    chk("u0 bit", 32'(so0), 32'(x0.b));
                    chk("u0 done", 32'(wd0), 32'(x0.d));
                    chk("u0 bit cycle", cyc, x0.c);
                end
            end else begin
                chk("u0 idle ser_out", 32'(so0), 0);
                chk("u0 stray done", 32'(wd0), 0);
            end
            if (sv3) begin
                if (q3.size() == 0) chk("u3 unexpected valid", 32'(sv3), 0);
                else begin
                    x3 = q3.pop_front();
                    chk("u3 bit", 32'(so3), 32'(x3.b));
                    chk("u3 done", 32'(wd3), 32'(x3.d));
                    chk("u3 bit cycle", cyc, x3.c);
                end
            end else begin
                chk("u3 idle ser_out", 32'(so3), 0);
                chk("u3 stray done", 32'(wd3), 0);
            end
            if (cyc >= glo && cyc <= ghi) begin
                chk("gap data_ready", 32'(dr3), 0);
                chk("gap ser_valid", 32'(sv3), 0);
            end
        end
    end

    task automatic acc(input int sel, input logic [7:0] w,
                       input bit keep, output int e);
        int n = 0;
        if (sel == 0) begin dv0 = 1'b1; din0 = w; end
        else begin dv3 = 1'b1; din3 = w; end
        while (((sel == 0) ? dr0 : dr3) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = cyc;
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL accept timeout: dut=%0d word=%0h", sel, w);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            if (sel == 0) dv0 = 1'b0;
            else dv3 = 1'b0;
        end
    endtask

    int e1, e2;

    initial begin
        rst  = 1'b0;
        dv0  = 1'b1;
        dv3  = 1'b1;
        din0 = 8'h3C;
        din3 = 8'h3C;
        repeat (2) begin
            @(negedge clk);
            chk("rst ser_out", 32'({so0, so3}), 0);
            chk("rst ser_valid", 32'({sv0, sv3}), 0);
            chk("rst word_done", 32'({wd0, wd3}), 0);
            chk("rst data_ready", 32'({dr0, dr3}), 0);
        end
        rst = 1'b1;
        dv0 = 1'b0;
        dv3 = 1'b0;
        #1;
        chk("ready after release", 32'({dr0, dr3}), 32'h3);
        chk("no accept in reset", 32'(q0.size() + q3.size()), 0);
        @(negedge clk);

        acc(0, 8'hA5, 1'b0, e1);
        repeat (12) @(negedge clk);

        acc(0, 8'hFF, 1'b1, e1);
        acc(0, 8'h00, 1'b0, e2);
        chk("b2b spacing", e2 - e1, 8 + PB);
        repeat (12) @(negedge clk);

        acc(3, 8'h81, 1'b1, e1);
        glo = e1 + 9 + PB;
        ghi = e1 + 11 + PB;
        acc(3, 8'h81, 1'b0, e2);
        chk("gap spacing", e2 - e1, 12 + PB);
        repeat (16) @(negedge clk);

        acc(0, 8'hF0, 1'b0, e1);
        while (cyc < e1 + 3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        q0.delete();
        #1;
        chk("abort ser_out", 32'(so0), 0);
        chk("abort ser_valid", 32'(sv0), 0);
        chk("abort word_done", 32'(wd0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        acc(0, 8'h0F, 1'b0, e1);
        repeat (16) @(negedge clk);

        chk("u0 queue drained", 32'(q0.size()), 0);
        chk("u3 queue drained", 32'(q3.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
